spec_free_list_ckpt: RTL and testbench
======================================

# spec_free_list_ckpt

Parametrised speculative physical-register free list for the rename stage, with N-way allocation, M-way compacted release and a bank of branch checkpoints. It supplies destination physical registers to the rename map each cycle and accepts registers released at retire. Branch-mispredict recovery restores the allocation head from a checkpoint in one cycle. A full pipeline flush marks every entry free.

## Interface
- DEPTH, 96: free-list entries. Equals physical regs minus architectural regs. Need not be a power of two.
- PHYS_LOG, 7: physical register tag width.
- ARCH_REGS, 32: first tag placed in the list at reset.
- ALLOC_W, 4: allocation lanes (dispatch width).
- FREE_W, 4: release lanes (commit width).
- NUM_CKPT, 4: checkpoint slots. CK_LOG = clog2(NUM_CKPT).
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- stall_i  in  1  rename stalled; no allocation this cycle.
- allocReq_i  in  ALLOC_W  per-lane request for a destination register.
- allocGrant_o  out  ALLOC_W  per-lane grant, combinational.
- allocReg_o  out  ALLOC_W*PHYS_LOG  granted tag; lane j at bits [j*PHYS_LOG +: PHYS_LOG].
- freeValid_i  in  FREE_W  per-lane release valid.
- freeReg_i  in  FREE_W*PHYS_LOG  released tags.
- ckptSave_i  in  1  snapshot the head into slot ckptId_i.
- ckptId_i  in  CK_LOG  slot to write.
- restore_i  in  1  mispredict: restore the head from slot restoreId_i.
- restoreId_i  in  CK_LOG  slot to read.
- flush_i  in  1  full recovery: every entry becomes free.
- count_o  out  clog2(DEPTH+1)  current free count.
- empty_o  out  1  count_o < ALLOC_W.

## Operation
- Storage:
  - Flop array of DEPTH tags.
  - head and tail pointers in 0..DEPTH-1, each with a phase bit that toggles on wrap.
  - Wrap is by subtraction of DEPTH, never by masking.
  - count = tail - head (mod DEPTH). When pointers are equal, count = DEPTH if phases differ, else 0.
- Reset:
  - entry i holds ARCH_REGS+i.
  - head = 0/phase 0; tail = 0/phase 1; count = DEPTH.
  - All checkpoint slots = 0/phase 0.
- Rank: rank(j) = popcount(allocReq_i[j-1:0]).
- Lane output: allocReg_o lane j = entry[(head + rank(j)) mod DEPTH]. The value is undefined when not granted.
- Grant: allocGrant_o[j] = allocReq_i[j] & ~stall_i & ~flush_i & ~restore_i & ok. ok = (count >= ALLOC_W); see Configuration.
- Head update: head advances by popcount(allocGrant_o).
- Release:
  - Valid lanes are compacted in lane order.
  - Written at tail, tail+1, ..., mod DEPTH.
  - tail advances by popcount(freeValid_i).
  - Release happens every non-reset cycle, including stall, restore and flush.
- Checkpoint save:
  - ckpt[ckptId_i] <= head after this cycle's allocation (head_next, with phase).
  - Same-cycle allocations are excluded from the snapshot.
- Restore: head <= ckpt[restoreId_i]. count is recomputed from tail_next and the restored head.
- Flush: head <= tail_next with the phase inverted, giving count = DEPTH.
- Priority: reset > flush > restore > normal.
  - ckptSave_i is ignored when flush or restore is active.
  - Grants are forced 0 during flush and restore.
- Overflow: releasing beyond DEPTH is a protocol violation. The simulation assertion fires (under `ifndef SYNTHESIS`). No clamping is applied.

## Timing
- allocReg_o and allocGrant_o are combinational from head, the array and the request inputs, in the same cycle.
- head, tail, count and the array update at the next edge.
- A register released in cycle N can be allocated no earlier than cycle N+1. There is no same-cycle bypass.
- Restore and flush take effect at the edge. The next cycle's allocation reads from the restored head.
- Outputs after reset:
  - count_o = DEPTH; empty_o = 0.
  - allocGrant_o = allocReq_i.
  - allocReg_o lane j = ARCH_REGS+rank(j).

## Configuration
- FREELIST_PARTIAL_ALLOC_EN undefined: all-or-nothing. ok = (count >= ALLOC_W) for every lane.
- FREELIST_PARTIAL_ALLOC_EN defined: per-lane. ok_j = (rank(j) < count), so lower-ranked requests are served even when count < ALLOC_W.
- empty_o keeps the same definition in both cases.

## Test plan
- Reset, then request 4'b1111 → grants 1111, tags 32,33,34,35; next cycle count_o = 92.
- Request 4'b1010 → lane1 gets 32, lane3 gets 33, head advances by 2; freeValid 4'b0101 with tags 40,41 → written at the tail, count +2.
- Drain to count = 3:
  - Macro off: 4-lane request → no grants, head unchanged.
  - Macro on: 3 grants, then count = 0.
  - Same cycle release of 4 → count_o = 4 next cycle.
- Wrap: set tail at 94 and release 4 → entries 94,95,0,1 written, phase toggles, count correct. Allocate across the 95→0 boundary → contiguous tags.
- Save ckpt 2 at head 10 while allocating 2 (snapshot = 12). Allocate 20 more. Restore 2 with 1 release that cycle → head = 12, count = tail_next - 12.
- Flush with stall and 2 releases in the same cycle → count_o = 96, head = tail_next, no grants. Concurrent ckptSave_i leaves the slot unchanged.

Source files
------------

// File: rtl/spec_free_list_ckpt.sv
// ---------------------------------------------------------------------------
// spec_free_list_ckpt
//
// Speculative physical-register free list for the rename stage.
// - Hands out up to ALLOC_W destination tags per cycle, starting at the head.
// - Accepts up to FREE_W released tags per cycle, packed in lane order at the tail.
// - Keeps NUM_CKPT head snapshots so a branch mispredict can rewind the head
//   in one cycle.
// - A flush marks every entry free.
//
// Optional feature macro: FREELIST_PARTIAL_ALLOC_EN
//   undefined : all-or-nothing allocation. Every lane needs count >= ALLOC_W.
//   defined   : per-lane allocation. Lane j is served while rank(j) < count.
//
// Ports
//   clk           clock, rising edge
//   reset         synchronous, active-high reset
//   stall_i       rename stalled, no allocation this cycle
//   allocReq_i    per-lane allocation request
//   allocGrant_o  per-lane grant (combinational)
//   allocReg_o    granted tag, lane j at [j*PHYS_LOG +: PHYS_LOG]
//   freeValid_i   per-lane release valid
//   freeReg_i     released tags, lane j at [j*PHYS_LOG +: PHYS_LOG]
//   ckptSave_i    snapshot the post-allocation head into slot ckptId_i
//   ckptId_i      checkpoint slot to write
//   restore_i     mispredict, reload the head from slot restoreId_i
//   restoreId_i   checkpoint slot to read
//   flush_i       full recovery, every entry becomes free
//   count_o       current free count
//   empty_o       count_o < ALLOC_W
// ---------------------------------------------------------------------------
module spec_free_list_ckpt #(
   parameter int unsigned DEPTH     = 96,
   parameter int unsigned PHYS_LOG  = 7,
   parameter int unsigned ARCH_REGS = 32,
   parameter int unsigned ALLOC_W   = 4,
   parameter int unsigned FREE_W    = 4,
   parameter int unsigned NUM_CKPT  = 4,
   localparam int unsigned CK_LOG   = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1,
   localparam int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         stall_i,
   input  logic [ALLOC_W-1:0]           allocReq_i,
   output logic [ALLOC_W-1:0]           allocGrant_o,
   output logic [ALLOC_W*PHYS_LOG-1:0]  allocReg_o,
   input  logic [FREE_W-1:0]            freeValid_i,
   input  logic [FREE_W*PHYS_LOG-1:0]   freeReg_i,
   input  logic                         ckptSave_i,
   input  logic [CK_LOG-1:0]            ckptId_i,
   input  logic                         restore_i,
   input  logic [CK_LOG-1:0]            restoreId_i,
   input  logic                         flush_i,
   output logic [CNT_W-1:0]             count_o,
   output logic                         empty_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Pointer with wrap phase; equal indices are full or empty depending on phase.
   typedef struct packed {
      logic             ph;
      logic [PTR_W-1:0] idx;
   } ptr_t;

   // Advance a pointer by n (n <= DEPTH). DEPTH need not be a power of two,
   // so wrap is done by subtraction rather than by masking.
   function automatic ptr_t ptr_adv(input ptr_t p, input int unsigned n);
      int unsigned s;
      ptr_t        r;
      s    = 32'(p.idx) + n;
      r.ph = p.ph;
      if (s >= DEPTH) begin
         s    = s - DEPTH;
         r.ph = ~p.ph;
      end
      r.idx = PTR_W'(s);
      return r;
   endfunction

   // Number of entries from h up to (not including) t.
   function automatic logic [CNT_W-1:0] ptr_dist(input ptr_t h, input ptr_t t);
      logic [CNT_W-1:0] d;
      if (t.idx > h.idx) begin
         d = CNT_W'(32'(t.idx) - 32'(h.idx));
      end else if (t.idx < h.idx) begin
         d = CNT_W'(DEPTH - 32'(h.idx) + 32'(t.idx));
      end else if (t.ph != h.ph) begin
         d = CNT_W'(DEPTH);
      end else begin
         d = '0;
      end
      return d;
   endfunction

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic [PHYS_LOG-1:0] mem_q  [DEPTH];
   logic [PHYS_LOG-1:0] mem_d  [DEPTH];
   ptr_t                ckpt_q [NUM_CKPT];
   ptr_t                ckpt_d [NUM_CKPT];
   ptr_t                head_q, head_d;
   ptr_t                tail_q, tail_d;

   logic [CNT_W-1:0]    cnt;
   int unsigned         rank [ALLOC_W];
   logic [ALLOC_W-1:0]  lane_ok;
   int unsigned         n_alloc;
   int unsigned         n_free;
   ptr_t                head_adv;

   assign cnt     = ptr_dist(head_q, tail_q);
   assign count_o = cnt;
   assign empty_o = (32'(cnt) < ALLOC_W);

   // -------------------------------------------------------------------------
   // Allocation: ranks, grants and read ports
   // -------------------------------------------------------------------------
   always_comb begin : alloc_comb
      int unsigned acc;
      ptr_t        rd;
      acc          = 0;
      n_alloc      = 0;
      lane_ok      = '0;
      allocGrant_o = '0;
      allocReg_o   = '0;
      rd           = head_q;
      for (int unsigned j = 0; j < ALLOC_W; j++) begin
         rank[j] = acc;
         if (allocReq_i[j]) begin
            acc = acc + 1;
         end
      end
      for (int unsigned j = 0; j < ALLOC_W; j++) begin
`ifdef FREELIST_PARTIAL_ALLOC_EN
         lane_ok[j] = (rank[j] < 32'(cnt));
`else
         lane_ok[j] = (32'(cnt) >= ALLOC_W);
`endif
         allocGrant_o[j] = allocReq_i[j] & ~stall_i & ~flush_i & ~restore_i & lane_ok[j];
         // The tag is driven from the rank slot even when not granted.
         rd = ptr_adv(head_q, rank[j]);
         allocReg_o[j*PHYS_LOG +: PHYS_LOG] = mem_q[rd.idx];
         if (allocGrant_o[j]) begin
            n_alloc = n_alloc + 1;
         end
      end
   end

   assign head_adv = ptr_adv(head_q, n_alloc);

   // -------------------------------------------------------------------------
   // Release: valid lanes packed in lane order at tail, tail+1, ...
   // -------------------------------------------------------------------------
   always_comb begin : release_comb
      ptr_t wr;
      mem_d  = mem_q;
      n_free = 0;
      wr     = tail_q;
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_d[i] = PHYS_LOG'(ARCH_REGS + i);
         end
      end else begin
         for (int unsigned i = 0; i < FREE_W; i++) begin
            if (freeValid_i[i]) begin
               wr = ptr_adv(tail_q, n_free);
               mem_d[wr.idx] = freeReg_i[i*PHYS_LOG +: PHYS_LOG];
               n_free = n_free + 1;
            end
         end
      end
   end

   assign tail_d = ptr_adv(tail_q, n_free);

   // -------------------------------------------------------------------------
   // Head recovery and checkpoints. flush > restore > normal.
   // -------------------------------------------------------------------------
   always_comb begin : head_comb
      ckpt_d = ckpt_q;
      if (flush_i) begin
         // Head lands on the new tail with opposite phase: all DEPTH entries free.
         head_d = '{ph: ~tail_d.ph, idx: tail_d.idx};
      end else if (restore_i) begin
         head_d = ckpt_q[restoreId_i];
      end else begin
         head_d = head_adv;
         // Snapshot excludes this cycle's allocations.
         if (ckptSave_i) begin
            ckpt_d[ckptId_i] = head_adv;
         end
      end
      if (reset) begin
         for (int unsigned i = 0; i < NUM_CKPT; i++) begin
            ckpt_d[i] = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q <= '0;
         tail_q <= '{ph: 1'b1, idx: '0};
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
      end
      mem_q  <= mem_d;
      ckpt_q <= ckpt_d;
   end

`ifndef SYNTHESIS
   // Releasing more than the list can hold corrupts the pointers; not clamped.
   always_ff @(posedge clk) begin
      if (!reset && !flush_i && !restore_i) begin
         assert (32'(cnt) + n_free <= DEPTH + n_alloc)
            else $error("free list overflow: count=%0d alloc=%0d free=%0d",
                        cnt, n_alloc, n_free);
      end
   end
`endif

endmodule

// File: tb/tb_spec_free_list_ckpt.sv
module tb_spec_free_list_ckpt;

   logic        clk;
   logic        reset;
   logic        stall;
   logic [3:0]  req;
   logic [3:0]  grant;
   logic [27:0] regs;
   logic [3:0]  fvalid;
   logic [27:0] freg;
   logic        save;
   logic [1:0]  cid;
   logic        rest;
   logic [1:0]  rid;
   logic        flush;
   logic [6:0]  cnt;
   logic        empty;

   int total = 0;
   int bad   = 0;

   spec_free_list_ckpt dut (
      .clk          (clk),
      .reset        (reset),
      .stall_i      (stall),
      .allocReq_i   (req),
      .allocGrant_o (grant),
      .allocReg_o   (regs),
      .freeValid_i  (fvalid),
      .freeReg_i    (freg),
      .ckptSave_i   (save),
      .ckptId_i     (cid),
      .restore_i    (rest),
      .restoreId_i  (rid),
      .flush_i      (flush),
      .count_o      (cnt),
      .empty_o      (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic            st;
      logic [3:0]      rq;
      logic [3:0]      fv;
      logic [3:0][6:0] ft;
      logic            sv;
      logic [1:0]      ci;
      logic            rs;
      logic [1:0]      ri;
      logic            fl;
      logic [3:0]      eg;
      logic [3:0][6:0] er;
      logic [6:0]      ec;
   } vec_t;

   function automatic logic [3:0][6:0] t4(input int a, input int b, input int c, input int d);
      logic [3:0][6:0] r;
      r[0] = 7'(a);
      r[1] = 7'(b);
      r[2] = 7'(c);
      r[3] = 7'(d);
      return r;
   endfunction

   function automatic vec_t mk(input int st, input int rq, input int fv,
                               input logic [3:0][6:0] ft, input int sv, input int ci,
                               input int rs, input int ri, input int fl, input int eg,
                               input logic [3:0][6:0] er, input int ec);
      vec_t v;
      v.st = 1'(st);
      v.rq = 4'(rq);
      v.fv = 4'(fv);
      v.ft = ft;
      v.sv = 1'(sv);
      v.ci = 2'(ci);
      v.rs = 1'(rs);
      v.ri = 2'(ri);
      v.fl = 1'(fl);
      v.eg = 4'(eg);
      v.er = er;
      v.ec = 7'(ec);
      return v;
   endfunction

   // Plain allocation row: no release, no recovery.
   function automatic vec_t al(input int rq, input int eg, input logic [3:0][6:0] er,
                               input int ec);
      return mk(0, rq, 0, '0, 0, 0, 0, 0, 0, eg, er, ec);
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      stall  = 1'b0;
      req    = '0;
      fvalid = '0;
      freg   = '0;
      save   = 1'b0;
      cid    = '0;
      rest   = 1'b0;
      rid    = '0;
      flush  = 1'b0;
   endtask

   task automatic reset_dut();
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Drive one row, check the combinational outputs, then clock it in.
   task automatic apply_row(input vec_t v, input string tag);
      stall  = v.st;
      req    = v.rq;
      fvalid = v.fv;
      freg   = v.ft;
      save   = v.sv;
      cid    = v.ci;
      rest   = v.rs;
      rid    = v.ri;
      flush  = v.fl;
      #1;
      check({tag, " count"}, 32'(cnt), 32'(v.ec));
      check({tag, " empty"}, 32'(empty), (v.ec < 7'd4) ? 32'd1 : 32'd0);
      check({tag, " grant"}, 32'(grant), 32'(v.eg));
      for (int j = 0; j < 4; j++) begin
         if (v.eg[j]) begin
            check($sformatf("%s reg%0d", tag, j), 32'(regs[j*7 +: 7]), 32'(v.er[j]));
         end
      end
      tick();
   endtask

   vec_t tbl[$];

   initial begin
      reset = 1'b1;
      idle_inputs();

      // -------- table: allocation, release, checkpoint, restore, flush --------
      tbl.push_back(al(15, 15, t4(32, 33, 34, 35), 96));
      tbl.push_back(al(15, 15, t4(36, 37, 38, 39), 92));
      // sparse request and sparse release (lanes 0 and 2 pack to tail, tail+1)
      tbl.push_back(mk(0, 'b1010, 'b0101, t4(100, 0, 101, 0), 0, 0, 0, 0, 0,
                       'b1010, t4(0, 40, 0, 41), 88));
      // save slot 2 at head 10 while allocating 2 -> snapshot 12
      tbl.push_back(mk(0, 'b0011, 0, '0, 1, 2, 0, 0, 0, 'b0011, t4(42, 43, 0, 0), 88));
      tbl.push_back(al(15, 15, t4(44, 45, 46, 47), 86));
      tbl.push_back(al(15, 15, t4(48, 49, 50, 51), 82));
      tbl.push_back(al(15, 15, t4(52, 53, 54, 55), 78));
      tbl.push_back(al(15, 15, t4(56, 57, 58, 59), 74));
      tbl.push_back(al(15, 15, t4(60, 61, 62, 63), 70));
      // restore slot 2 with one release (lane 2) in the same cycle
      tbl.push_back(mk(0, 15, 'b0100, t4(0, 0, 99, 0), 0, 0, 1, 2, 0, 0, '0, 66));
      tbl.push_back(al(15, 15, t4(44, 45, 46, 47), 87));
      // flush + stall + two releases + ignored save into slot 2
      tbl.push_back(mk(1, 15, 'b1001, t4(70, 0, 0, 71), 1, 2, 0, 0, 1, 0, '0, 83));
      tbl.push_back(al(15, 15, t4(37, 38, 39, 40), 96));
      // slot 2 must still hold 12
      tbl.push_back(mk(0, 1, 0, '0, 0, 0, 1, 2, 0, 0, '0, 92));
      tbl.push_back(al(15, 15, t4(44, 45, 46, 47), 89));
      // slot 1 was never saved: reset value 0/phase 0 leaves 5 released tags
      tbl.push_back(mk(0, 0, 0, '0, 0, 0, 1, 1, 0, 0, '0, 85));
      tbl.push_back(al(15, 15, t4(100, 101, 99, 70), 5));
`ifdef FREELIST_PARTIAL_ALLOC_EN
      tbl.push_back(al(1, 1, t4(71, 0, 0, 0), 1));
`else
      tbl.push_back(al(1, 0, '0, 1));
`endif

      reset_dut();
      // reset state
      #1;
      check("reset count", 32'(cnt), 32'd96);
      check("reset empty", 32'(empty), 32'd0);
      check("reset grant idle", 32'(grant), 32'd0);
      tick();
      for (int i = 0; i < tbl.size(); i++) begin
         apply_row(tbl[i], $sformatf("row%0d", i));
      end

      // -------- drain to count 3, then a full request with 4 releases --------
      reset_dut();
      for (int k = 0; k < 23; k++) begin
         apply_row(al(15, 15, t4(32 + 4*k, 33 + 4*k, 34 + 4*k, 35 + 4*k), 96 - 4*k),
                   $sformatf("drain%0d", k));
      end
      apply_row(al(1, 1, t4(124, 0, 0, 0), 4), "drain_last");
`ifdef FREELIST_PARTIAL_ALLOC_EN
      apply_row(mk(0, 15, 15, t4(50, 51, 52, 53), 0, 0, 0, 0, 0, 'b0111,
                   t4(125, 126, 127, 0), 3), "short");
      apply_row(al(15, 15, t4(50, 51, 52, 53), 4), "after_short");
`else
      apply_row(mk(0, 15, 15, t4(50, 51, 52, 53), 0, 0, 0, 0, 0, 0, '0, 3), "short");
      apply_row(al(15, 15, t4(125, 126, 127, 50), 7), "after_short");
`endif

      // -------- tail wrap: put tail at 94, release 4, allocate across 95->0 ----
      reset_dut();
      apply_row(al(15, 15, t4(32, 33, 34, 35), 96), "wrap_a0");
      for (int k = 0; k < 23; k++) begin
         apply_row(mk(0, 15, 15, t4(4*k, 4*k + 1, 4*k + 2, 4*k + 3), 0, 0, 0, 0, 0, 15,
                      t4(36 + 4*k, 37 + 4*k, 38 + 4*k, 39 + 4*k), 92),
                   $sformatf("churn%0d", k));
      end
      apply_row(mk(0, 15, 3, t4(1, 2, 0, 0), 0, 0, 0, 0, 0, 15, t4(0, 1, 2, 3), 92),
                "to_94");
      apply_row(mk(1, 0, 15, t4(10, 11, 12, 13), 0, 0, 0, 0, 0, 0, '0, 90), "tail_wrap");
      for (int k = 0; k < 22; k++) begin
         apply_row(al(15, 15, t4(4 + 4*k, 5 + 4*k, 6 + 4*k, 7 + 4*k), 94 - 4*k),
                   $sformatf("walk%0d", k));
      end
      apply_row(al(3, 3, t4(1, 2, 0, 0), 6), "head_94");
      apply_row(al(15, 15, t4(10, 11, 12, 13), 4), "head_wrap");
      apply_row(al(1, 0, '0, 0), "zero");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
